// File: rtl/axby_seq.sv
// axby_seq: sequential shift-and-add unit computing a*x + b*y over W cycles per
// product, with optional accumulation onto the previously held result.
// Handshake: pulse start while idle; done pulses once when result is valid.
module axby_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           acc_en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*W:0]   result,
    output logic           overflow
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULX = 2'd1,
        MULY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg,   state_next;
    logic [2*W:0]    acc_reg,     acc_next;
    logic [2*W:0]    mcand_reg,   mcand_next;
    logic [W-1:0]    mplier_reg,  mplier_next;
    logic [W-1:0]    b_hold_reg,  b_hold_next;
    logic [W-1:0]    y_hold_reg,  y_hold_next;
    logic [CW-1:0]   cnt_reg,     cnt_next;
    logic [2*W:0]    result_reg,  result_next;
    logic            acc_ovf_reg, acc_ovf_next;
    logic            ovf_reg,     ovf_next;
    logic            done_reg,    done_next;
    logic            busy_reg,    busy_next;

    // One extra bit above acc catches the carry out of bit 2W.
    logic [2*W+1:0]  sum;

    assign sum      = {1'b0, acc_reg} + {1'b0, mcand_reg};
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign overflow = ovf_reg;

    // Next-state and datapath update; every register holds unless changed below.
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        b_hold_next  = b_hold_reg;
        y_hold_next  = y_hold_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        acc_ovf_next = acc_ovf_reg;
        ovf_next     = ovf_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                // The done-pulse cycle is still part of the busy window, so a
                // start seen while done is high must not be accepted.
                if (start && !done_reg) begin
                    mcand_next  = {{(W+1){1'b0}}, a};
                    mplier_next = x;
                    b_hold_next = b;
                    y_hold_next = y;
                    cnt_next    = '0;
                    if (acc_en) begin
                        acc_next     = result_reg;
                        acc_ovf_next = ovf_reg;
                    end else begin
                        acc_next     = '0;
                        acc_ovf_next = 1'b0;
                    end
                    state_next = MULX;
                end
            end
            MULX, MULY: begin
                if (mplier_reg[0]) begin
                    acc_next = sum[2*W:0];
                    if (sum[2*W+1]) begin
                        acc_ovf_next = 1'b1;
                    end
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (state_reg == MULX) begin
                        mcand_next  = {{(W+1){1'b0}}, b_hold_reg};
                        mplier_next = y_hold_reg;
                        state_next  = MULY;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // Only here does the finished sum become visible.
                result_next = acc_reg;
                ovf_next    = acc_ovf_reg;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Busy stays up through the done pulse and drops together with it.
        busy_next = (state_next != IDLE) || done_next;
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            b_hold_reg  <= '0;
            y_hold_reg  <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            acc_ovf_reg <= 1'b0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            b_hold_reg  <= b_hold_next;
            y_hold_reg  <= y_hold_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            acc_ovf_reg <= acc_ovf_next;
            ovf_reg     <= ovf_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
        end
    end

endmodule

// File: tb/tb_axby_seq.sv
// Testbench for axby_seq: W=8 and W=4 instances, scoreboard of expected
// results pushed at start and popped when done pulses.
module tb_axby_seq;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        start8 = 1'b0;
    logic        start4 = 1'b0;
    logic        acc_en = 1'b0;
    logic [7:0]  a = '0, b = '0, x = '0, y = '0;

    logic        busy8, done8, ovf8;
    logic [16:0] result8;
    logic        busy4, done4, ovf4;
    logic [8:0]  result4;

    typedef struct {
        int     w;
        longint res;
        bit     ovf;
    } exp_t;

    exp_t   sb[$];
    longint m_res8 = 0, m_res4 = 0;
    bit     m_ovf8 = 0, m_ovf4 = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    axby_seq #(.W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .acc_en(acc_en),
        .a(a), .b(b), .x(x), .y(y),
        .busy(busy8), .done(done8), .result(result8), .overflow(ovf8)
    );

    axby_seq #(.W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .acc_en(acc_en),
        .a(a[3:0]), .b(b[3:0]), .x(x[3:0]), .y(y[3:0]),
        .busy(busy4), .done(done4), .result(result4), .overflow(ovf4)
    );

    // One operation on the selected instance: model, push, drive, then watch
    // for done. Start is re-asserted after edges ign_a/ign_b/ign_c (0 = never).
    task automatic run_op(input int w, input int ia, input int ix, input int ib, input int iy,
                          input bit ien, input int ign_a, input int ign_b, input int ign_c,
                          input int last_k, input string tag);
        longint lim, prod, tot, prev, got_res;
        bit     pov, got_ovf, cur_done, cur_busy, st;
        exp_t   e, q;
        int     busy_cnt, done_cnt, done_k;
        lim  = longint'(1) << (2 * w + 1);
        prev = (w == 8) ? m_res8 : m_res4;
        pov  = (w == 8) ? m_ovf8 : m_ovf4;
        prod = longint'(ia) * longint'(ix) + longint'(ib) * longint'(iy);
        tot  = ien ? prev + prod : prod;
        e.w   = w;
        e.res = tot % lim;
        e.ovf = (ien && pov) || (tot >= lim);
        if (w == 8) begin m_res8 = e.res; m_ovf8 = e.ovf; end
        else        begin m_res4 = e.res; m_ovf4 = e.ovf; end
        sb.push_back(e);

        a = 8'(ia); x = 8'(ix); b = 8'(ib); y = 8'(iy); acc_en = ien;
        if (w == 8) start8 = 1'b1; else start4 = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_k = 0;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            st = (k == ign_a) || (k == ign_b) || (k == ign_c);
            if (w == 8) start8 = st; else start4 = st;
            if (k == 1) begin
                // Operands are latched; scramble them to prove it.
                a = 8'($urandom); b = 8'($urandom); x = 8'($urandom); y = 8'($urandom);
                acc_en = 1'($urandom);
            end
            cur_done = (w == 8) ? done8 : done4;
            cur_busy = (w == 8) ? busy8 : busy4;
            if (cur_busy) busy_cnt++;
            if (cur_done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
                got_res = (w == 8) ? longint'(result8) : longint'(result4);
                got_ovf = (w == 8) ? ovf8 : ovf4;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected_done: got done at edge %0d, required no done", tag, k);
                end else begin
                    q = sb.pop_front();
                    if (got_res !== q.res) begin
                        n_fail++;
                        $display("FAIL %s result: got %0d, required %0d", tag, got_res, q.res);
                    end
                    n_checks++;
                    if (got_ovf !== q.ovf) begin
                        n_fail++;
                        $display("FAIL %s overflow: got %0d, required %0d", tag, got_ovf, q.ovf);
                    end
                end
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d, required 1", tag, done_cnt);
        end
        n_checks++;
        if (done_k !== 2 * w + 2) begin
            n_fail++;
            $display("FAIL %s latency: done after %0d edges, required %0d", tag, done_k, 2 * w + 2);
        end
        n_checks++;
        if (busy_cnt !== 2 * w + 2) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", tag, busy_cnt, 2 * w + 2);
        end
        if (done_cnt == 0) sb.delete();
        $display("op %s W=%0d a=%0d x=%0d b=%0d y=%0d acc_en=%0d -> expected result=%0d overflow=%0d",
                 tag, w, ia, ix, ib, iy, ien, e.res, e.ovf);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy8, done8, ovf8} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags8: got busy/done/ovf=%b, required 000", {busy8, done8, ovf8});
        end
        n_checks++;
        if (result8 !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_result8: got %0d, required 0", result8);
        end
        n_checks++;
        if ({busy4, done4, ovf4} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags4: got busy/done/ovf=%b, required 000", {busy4, done4, ovf4});
        end
        n_checks++;
        if (result4 !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_result4: got %0d, required 0", result4);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        run_op(8, 3, 5, 7, 2, 1'b0, 0, 0, 0, 28, "basic");
    endtask

    task automatic test_max_accumulate();
        run_op(8, 255, 255, 255, 255, 1'b0, 0, 0, 0, 28, "max");
        run_op(8, 1, 1, 0, 0, 1'b1, 0, 0, 0, 28, "max_acc");
    endtask

    task automatic test_w4_overflow();
        run_op(4, 15, 15, 15, 15, 1'b0, 0, 0, 0, 20, "w4_max");
        run_op(4, 15, 15, 15, 15, 1'b1, 0, 0, 0, 20, "w4_ovf");
        run_op(4, 1, 1, 0, 0, 1'b0, 0, 0, 0, 20, "w4_clear");
    endtask

    task automatic test_zero_multipliers();
        run_op(8, 200, 0, 200, 0, 1'b0, 0, 0, 0, 28, "zero_xy");
        run_op(8, 0, 9, 10, 0, 1'b0, 0, 0, 0, 28, "zero_mix");
    endtask

    // Starts during MULX, DONE and the done cycle are ignored; the op ends in
    // the first idle cycle so the next call starts back-to-back.
    task automatic test_back_to_back();
        run_op(8, 100, 50, 25, 4, 1'b0, 3, 17, 18, 19, "ignored_start");
        run_op(8, 11, 13, 17, 19, 1'b1, 0, 0, 0, 28, "back_to_back");
    endtask

    task automatic test_reset_mid();
        int dc;
        a = 8'd77; x = 8'd88; b = 8'd99; y = 8'd111; acc_en = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy_before: got %0d, required 1", busy8);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_res8 = 0; m_ovf8 = 0; m_res4 = 0; m_ovf4 = 0;
        dc = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (done8) dc++;
        end
        n_checks++;
        if (dc !== 0) begin
            n_fail++;
            $display("FAIL midreset_done: got %0d pulses, required 0", dc);
        end
        n_checks++;
        if ({busy8, ovf8} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_flags: got busy/ovf=%b, required 00", {busy8, ovf8});
        end
        n_checks++;
        if (result8 !== 17'd0) begin
            n_fail++;
            $display("FAIL midreset_result: got %0d, required 0", result8);
        end
        $display("midreset: aborted op in MULY");
        run_op(8, 2, 3, 4, 5, 1'b0, 0, 0, 0, 28, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_accumulate();
        test_w4_overflow();
        test_zero_multipliers();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
